// File: rtl/tick_receiver.sv
// ---------------------------------------------------------------------------
// tick_receiver
//
// Receiver side of the slow timebase. A free-running slow square wave
// (clk_in, asynchronous to clk_100MHz) is synchronized, edge-detected and
// turned into single-cycle clock-enable pulses (tick) in the clk_100MHz
// domain. Every period between rising edges is measured and classified
// against NOMINAL_PERIOD +/- TOLERANCE. The block then reports lock status
// and sticky early/late faults.
//
// Parameters:
//   SYNC_STAGES    - synchronizer depth on clk_in (>= 2)
//   NOMINAL_PERIOD - expected clk_100MHz cycles between clk_in rising edges
//   TOLERANCE      - allowed deviation in cycles, inclusive, either direction
//   LOCK_COUNT     - consecutive good periods needed to assert locked (>= 1)
//
// Ports:
//   clk_100MHz   in   system clock
//   reset        in   asynchronous active-high reset
//   clk_in       in   slow timebase input (asynchronous)
//   clear_err    in   one-cycle clear of err_early / err_late
//   tick         out  one-cycle pulse per detected rising edge of clk_in
//   period       out  last measured period in clk_100MHz cycles
//   period_valid out  one-cycle pulse when period is updated
//   locked       out  timebase stable
//   err_early    out  sticky: a period below the lower bound was measured
//   err_late     out  sticky: no edge within NOMINAL_PERIOD+TOLERANCE cycles
// ---------------------------------------------------------------------------
module tick_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned NOMINAL_PERIOD = 50_000_000,
  parameter int unsigned TOLERANCE      = 1000,
  parameter int unsigned LOCK_COUNT     = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        clk_in,
  input  logic        clear_err,
  output logic        tick,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        err_early,
  output logic        err_late
);

  // Classification bounds, all unsigned 32-bit.
  localparam logic [31:0] LOWER_BOUND = 32'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [31:0] UPPER_BOUND = 32'(NOMINAL_PERIOD + TOLERANCE);
  // Measured interval value at which the period is declared late.
  localparam logic [31:0] TIMEOUT_VAL = 32'(NOMINAL_PERIOD + TOLERANCE + 1);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [GW-1:0]          good_cnt_q, good_cnt_d;
  logic                   tick_q, tick_d;
  logic [31:0]            period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   locked_q, locked_d;
  logic                   err_early_q, err_early_d;
  logic                   err_late_q, err_late_d;

  // -------------------------------------------------------------------------
  // Synchronizer and edge detect
  // -------------------------------------------------------------------------
  logic sync_out;
  logic edge_det;

  // clk_in enters at bit 0 and shifts toward the MSB, which is the
  // synchronized copy.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], clk_in};
    sync_out = sync_q[SYNC_STAGES-1];
    prev_d   = sync_out;
    edge_det = sync_out & ~prev_q;
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  logic [31:0]   meas;
  logic [GW-1:0] good_inc;
  logic          is_early;
  logic          is_good;

  always_comb begin
    // Interval including the current cycle.
    meas     = cnt_q + 32'd1;
    good_inc = good_cnt_q + GW'(1);
    is_early = (meas < LOWER_BOUND);
    is_good  = !is_early && (meas <= UPPER_BOUND);

    state_d        = state_q;
    cnt_d          = cnt_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    tick_d         = edge_det;
    // clear_err drops the sticky flags; an error event below overrides it.
    err_early_d    = clear_err ? 1'b0 : err_early_q;
    err_late_d     = clear_err ? 1'b0 : err_late_q;

    unique case (state_q)
      S_IDLE: begin
        // No reference edge yet, so nothing to measure.
        cnt_d = 32'd0;
        if (edge_det) begin
          state_d = S_ACQUIRE;
        end
      end

      S_ACQUIRE, S_LOCKED: begin
        if (edge_det) begin
          cnt_d          = 32'd0;
          period_d       = meas;
          period_valid_d = 1'b1;
          if (is_early) begin
            err_early_d = 1'b1;
            good_cnt_d  = 32'd0 == 32'd0 ? '0 : good_cnt_q;
            state_d     = S_ACQUIRE;
          end else if (is_good) begin
            if (state_q == S_ACQUIRE) begin
              // good_cnt_q < LOCK_COUNT while acquiring, so good_inc fits.
              good_cnt_d = good_inc;
              if (good_inc >= LOCK_TARGET) begin
                state_d = S_LOCKED;
              end
            end
          end else begin
            // An edge landing exactly on the timeout cycle measures one
            // past the upper bound. It is not flagged late (the timeout
            // did not fire) but it cannot count as good, so restart
            // acquisition.
            good_cnt_d = '0;
            state_d    = S_ACQUIRE;
          end
        end else if (meas == TIMEOUT_VAL) begin
          // The counter never runs past this point, so it cannot saturate.
          err_late_d = 1'b1;
          good_cnt_d = '0;
          cnt_d      = 32'd0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = meas;
        end
      end

      default: begin
        state_d    = S_IDLE;
        cnt_d      = 32'd0;
        good_cnt_d = '0;
      end
    endcase

    locked_d = (state_d == S_LOCKED);
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      state_q        <= S_IDLE;
      cnt_q          <= 32'd0;
      good_cnt_q     <= '0;
      tick_q         <= 1'b0;
      period_q       <= 32'd0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_early_q    <= 1'b0;
      err_late_q     <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      tick_q         <= tick_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_early_q    <= err_early_d;
      err_late_q     <= err_late_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err_early    = err_early_q;
  assign err_late     = err_late_q;

endmodule

// File: tb/tb_tick_receiver.sv
// ---------------------------------------------------------------------------
// tb_tick_receiver
//
// Directed bench for tick_receiver with SYNC_STAGES=2, NOMINAL_PERIOD=100,
// TOLERANCE=2, LOCK_COUNT=2. clk_in is changed 1 time unit after a rising
// clk_100MHz edge, and outputs are sampled 1 time unit after an edge.
// A rise set just after edge k is sampled at edge k+1, so tick is
// expected to be high right after edge k+3.
// ---------------------------------------------------------------------------
module tb_tick_receiver;

  logic        clk_100MHz;
  logic        reset;
  logic        clk_in;
  logic        clear_err;
  logic        tick;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        err_early;
  logic        err_late;

  int n_checks = 0;
  int n_fail   = 0;

  tick_receiver #(
    .SYNC_STAGES   (2),
    .NOMINAL_PERIOD(100),
    .TOLERANCE     (2),
    .LOCK_COUNT    (2)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .clk_in      (clk_in),
    .clear_err   (clear_err),
    .tick        (tick),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .err_early   (err_early),
    .err_late    (err_late)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Advance one clock and land 1 time unit past the edge.
  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".tick"}, {31'd0, tick}, 32'd0);
    chk({tag, ".period"}, period, 32'd0);
    chk({tag, ".pv"}, {31'd0, period_valid}, 32'd0);
    chk({tag, ".locked"}, {31'd0, locked}, 32'd0);
    chk({tag, ".early"}, {31'd0, err_early}, 32'd0);
    chk({tag, ".late"}, {31'd0, err_late}, 32'd0);
  endtask

  // One clk_in period of len cycles starting with a rise. The expected
  // values describe the outputs right after the tick produced by this rise
  // (so exp_period is the length of the previous call's period).
  // clr_at_edge raises clear_err during the edge-detect cycle.
  task automatic cycle(input string tag, input int len, input logic exp_pv,
                       input logic [31:0] exp_period, input logic exp_locked,
                       input logic exp_early, input logic exp_late,
                       input logic clr_at_edge);
    clk_in = 1'b1;
    step();
    step();
    chk({tag, ".tick_pre"}, {31'd0, tick}, 32'd0);
    if (clr_at_edge) clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk({tag, ".tick"}, {31'd0, tick}, 32'd1);
    chk({tag, ".pv"}, {31'd0, period_valid}, {31'd0, exp_pv});
    chk({tag, ".period"}, period, exp_period);
    chk({tag, ".locked"}, {31'd0, locked}, {31'd0, exp_locked});
    chk({tag, ".early"}, {31'd0, err_early}, {31'd0, exp_early});
    chk({tag, ".late"}, {31'd0, err_late}, {31'd0, exp_late});
    step();
    chk({tag, ".tick_post"}, {31'd0, tick}, 32'd0);
    chk({tag, ".pv_post"}, {31'd0, period_valid}, 32'd0);
    for (int i = 4; i < len; i++) begin
      if (i == len / 2) clk_in = 1'b0;
      step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    clk_in    = 1'b0;
    clear_err = 1'b0;

    // Reset held while clk_in toggles: nothing may come out.
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) clk_in = ~clk_in;
      step();
      if (i % 4 == 3) chk_all_zero("in_reset");
    end
    clk_in = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_all_zero("post_reset");
    $display("reset phase done");

    // Acquire and lock on a 100-cycle square wave.
    cycle("e1", 100, 1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    $display("edge1: tick only");
    cycle("e2", 100, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("edge2: period 100");
    cycle("e3", 98,  1'b1, 32'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("edge3: locked");
    // Boundaries 98 and 102 are good; 97 is early.
    cycle("e4", 102, 1'b1, 32'd98,  1'b1, 1'b0, 1'b0, 1'b0);
    $display("edge4: period 98 good");
    cycle("e5", 97,  1'b1, 32'd102, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("edge5: period 102 good");
    cycle("e6", 100, 1'b1, 32'd97,  1'b0, 1'b1, 1'b0, 1'b0);
    $display("edge6: period 97 early");
    cycle("e7", 100, 1'b1, 32'd100, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("edge7: reacquiring");
    cycle("e8", 100, 1'b1, 32'd100, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("edge8: relocked");

    // clear_err alone (adds one cycle: next period is 101).
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr1.early", {31'd0, err_early}, 32'd0);
    chk("clr1.late", {31'd0, err_late}, 32'd0);
    chk("clr1.locked", {31'd0, locked}, 32'd1);
    $display("clear_err alone: flags cleared");

    cycle("e9",  97,  1'b1, 32'd101, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("edge9: period 101");
    // Early detection with clear_err in the same cycle: flag survives.
    cycle("e10", 100, 1'b1, 32'd97,  1'b0, 1'b1, 1'b0, 1'b1);
    $display("edge10: early wins over clear");
    cycle("e11", 100, 1'b1, 32'd100, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("edge11: reacquiring");
    cycle("e12", 100, 1'b1, 32'd100, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("edge12: relocked");

    // Stop clk_in. 97 cycles have passed since the tick; timeout at 103.
    for (int i = 0; i < 5; i++) step();
    chk("to_pre.late", {31'd0, err_late}, 32'd0);
    chk("to_pre.locked", {31'd0, locked}, 32'd1);
    step();
    chk("to.late", {31'd0, err_late}, 32'd1);
    chk("to.locked", {31'd0, locked}, 32'd0);
    $display("timeout: err_late at 103 cycles");
    for (int i = 0; i < 20; i++) step();

    cycle("e13", 100, 1'b0, 32'd100, 1'b0, 1'b1, 1'b1, 1'b0);
    $display("edge13: tick only after timeout");
    cycle("e14", 100, 1'b1, 32'd100, 1'b0, 1'b1, 1'b1, 1'b0);
    $display("edge14: reacquiring");
    cycle("e15", 100, 1'b1, 32'd100, 1'b1, 1'b1, 1'b1, 1'b0);
    $display("edge15: relocked");

    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr2.early", {31'd0, err_early}, 32'd0);
    chk("clr2.late", {31'd0, err_late}, 32'd0);
    $display("clear_err alone: both flags cleared");

    cycle("e16", 100, 1'b1, 32'd101, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("edge16: period 101");

    // Reset 50 cycles into a locked period.
    clk_in = 1'b1;
    step();
    step();
    step();
    chk("e17.tick", {31'd0, tick}, 32'd1);
    chk("e17.period", period, 32'd100);
    chk("e17.locked", {31'd0, locked}, 32'd1);
    for (int i = 3; i < 50; i++) begin
      if (i == 20) clk_in = 1'b0;
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    $display("async reset mid-period: outputs cleared");
    for (int i = 0; i < 6; i++) begin
      clk_in = ~clk_in;
      step();
      chk("mid_reset.tick", {31'd0, tick}, 32'd0);
    end
    clk_in = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();

    cycle("r1", 100, 1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    $display("after reset edge1: tick only");
    cycle("r2", 100, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("after reset edge2: period 100");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
